draw_scheduler: RTL and testbench

- Command front-end that sits directly upstream of the framebuffer copy engine.
- Game logic pushes draw requests (position, source memory, tile, black flag) into an internal FIFO. The scheduler issues them to the copy engine one at a time and holds the command fields stable while each operation runs.
- On each frame tick it schedules one full-screen refresh, which copies the buffer to the VGA adapter.
- It guarantees go and refresh are never asserted together, and are never asserted while the engine is busy.

---
 rtl/draw_scheduler.sv | 178 +++++++++++++++++
 tb/tb_draw_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Purpose: queues draw requests and issues them one at a time to the framebuffer copy
//          engine, interleaving one full-screen refresh per frame tick.
// Latency: a request pushed in cycle N produces go in cycle N+2 at the earliest.
//          At least two cycles separate copy_finished from the next go/refresh.
// Backpressure: req_ready falls when the FIFO holds DEPTH entries; the engine
//          paces issue through copy_finished.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_x/y/mem/tile/black  request fields
//   frame_tick              one pulse per frame; requests a refresh
//   copy_finished           engine done pulse
//   go / refresh            one-cycle start pulses to the engine (never together)
//   X/Y/memory_select/tile_select/black   held command fields
//   busy                    an engine operation is outstanding
//   frame_done              pulses the cycle after a refresh completes
//   frame_dropped           pulses when a tick arrives with a refresh already pending
//   count                   FIFO occupancy
module draw_scheduler #(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int MAX_DEFER = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [8:0]        req_x,
    input  logic [7:0]        req_y,
    input  logic [1:0]        req_mem,
    input  logic [3:0]        req_tile,
    input  logic              req_black,
    input  logic              frame_tick,
    input  logic              copy_finished,
    output logic              go,
    output logic              refresh,
    output logic [8:0]        X,
    output logic [7:0]        Y,
    output logic [1:0]        memory_select,
    output logic [3:0]        tile_select,
    output logic              black,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_dropped,
    output logic [ADDR_W:0]   count
);

    localparam int DEFER_W = $clog2(MAX_DEFER + 1);
    localparam logic [ADDR_W:0]    DEPTH_C     = DEPTH[ADDR_W:0];
    localparam logic [DEFER_W-1:0] MAX_DEFER_C = MAX_DEFER[DEFER_W-1:0];

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_DRAW,
        ISSUE_REFRESH,
        WAIT_DONE,
        GAP
    } state_t;

    state_t state, state_nxt;

    logic [23:0]        fifo_mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count_q;
    logic [23:0]        cmd_q;
    logic               refresh_pending;
    logic               is_refresh;
    logic [DEFER_W-1:0] defer_cnt;
    logic               push;
    logic               pop;
    logic               take_refresh;

    assign req_ready = (count_q < DEPTH_C);
    assign push      = req_valid & req_ready;
    assign count     = count_q;

    // A pending refresh goes first when there is nothing to draw, or once the
    // queue has been allowed MAX_DEFER draws ahead of it.
    assign take_refresh = refresh_pending & ((count_q == '0) | (defer_cnt >= MAX_DEFER_C));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (take_refresh) begin
                    state_nxt = ISSUE_REFRESH;
                end else if (count_q != '0) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE_DRAW;
                end
            end
            ISSUE_DRAW:    state_nxt = WAIT_DONE;
            ISSUE_REFRESH: state_nxt = WAIT_DONE;
            WAIT_DONE:     if (copy_finished) state_nxt = GAP;
            GAP:           state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    assign go      = (state == ISSUE_DRAW);
    assign refresh = (state == ISSUE_REFRESH);
    assign busy    = (state != IDLE);

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {req_x, req_y, req_mem, req_tile, req_black};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            cmd_q   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (pop)  cmd_q  <= fifo_mem[rd_ptr];
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign X             = cmd_q[23:15];
    assign Y             = cmd_q[14:7];
    assign memory_select = cmd_q[6:5];
    assign tile_select   = cmd_q[4:1];
    assign black         = cmd_q[0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            refresh_pending <= 1'b0;
            defer_cnt       <= '0;
            is_refresh      <= 1'b0;
            frame_done      <= 1'b0;
            frame_dropped   <= 1'b0;
        end else begin
            // A tick in the issue cycle re-arms pending: the tick wins over the clear.
            if (frame_tick) begin
                refresh_pending <= 1'b1;
            end else if (state == ISSUE_REFRESH) begin
                refresh_pending <= 1'b0;
            end

            if (state == ISSUE_REFRESH) begin
                defer_cnt <= '0;
            end else if ((state == ISSUE_DRAW) && refresh_pending && (defer_cnt < MAX_DEFER_C)) begin
                defer_cnt <= defer_cnt + 1'b1;
            end

            if (state == ISSUE_REFRESH) begin
                is_refresh <= 1'b1;
            end else if (state == ISSUE_DRAW) begin
                is_refresh <= 1'b0;
            end

            frame_done    <= (state == WAIT_DONE) & copy_finished & is_refresh;
            frame_dropped <= frame_tick & refresh_pending;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Purpose: self-checking bench for draw_scheduler: a cycle table for the single
//          draw / refresh / drop behaviour, then sequences for FIFO fill, deferral and reset.
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [8:0] req_x;
    logic [7:0] req_y;
    logic [1:0] req_mem;
    logic [3:0] req_tile;
    logic       req_black;
    logic       frame_tick;
    logic       copy_finished;
    logic       go;
    logic       refresh;
    logic [8:0] X;
    logic [7:0] Y;
    logic [1:0] memory_select;
    logic [3:0] tile_select;
    logic       black;
    logic       busy;
    logic       frame_done;
    logic       frame_dropped;
    logic [4:0] count;

    int checks   = 0;
    int failures = 0;

    // Engine stand-in: fires copy_finished eng_lat cycles after a start unless held.
    logic tb_cf  = 1'b0;
    logic eng_cf = 1'b0;
    logic eng_en = 1'b0;
    logic eng_hold = 1'b0;
    int   eng_lat = 2;
    int   eng_timer = 0;
    assign copy_finished = tb_cf | eng_cf;

    // Issue log: {0,X} for a go, 10'h200 for a refresh.
    localparam logic [9:0] REF = 10'h200;
    logic [9:0] log_q[$];
    int n_go = 0, n_ref = 0, n_fd = 0, n_drop = 0;

    draw_scheduler #(.DEPTH(16), .ADDR_W(4), .MAX_DEFER(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_mem(req_mem), .req_tile(req_tile), .req_black(req_black),
        .frame_tick(frame_tick), .copy_finished(copy_finished),
        .go(go), .refresh(refresh),
        .X(X), .Y(Y), .memory_select(memory_select), .tile_select(tile_select), .black(black),
        .busy(busy), .frame_done(frame_done), .frame_dropped(frame_dropped), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        eng_cf = 1'b0;
        if (!eng_en) begin
            eng_timer = 0;
        end else if (go || refresh) begin
            eng_timer = eng_lat;
        end else if (eng_timer > 1) begin
            eng_timer = eng_timer - 1;
        end else if (eng_timer == 1 && !eng_hold) begin
            eng_cf    = 1'b1;
            eng_timer = 0;
        end
    end

    always @(negedge clk) begin
        if (go || refresh) chk("go_refresh_exclusive", {30'd0, go, refresh} == 32'd3, 0);
        if (go)            begin log_q.push_back({1'b0, X}); n_go++;  end
        if (refresh)       begin log_q.push_back(REF);       n_ref++; end
        if (frame_done)    n_fd++;
        if (frame_dropped) n_drop++;
    end

    typedef struct packed {
        logic       vld, tick, cf;
        logic       go, rf, busy, fd, drop;
        logic [4:0] cnt;
        logic [8:0] x;
    } vec_t;

    function automatic vec_t mk(input logic vld, input logic tick, input logic cf,
                                input logic g, input logic rf, input logic bz,
                                input logic fd, input logic dr, input logic [4:0] c,
                                input logic [8:0] x);
        vec_t v;
        v.vld = vld; v.tick = tick; v.cf = cf;
        v.go = g; v.rf = rf; v.busy = bz; v.fd = fd; v.drop = dr; v.cnt = c; v.x = x;
        return v;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_req(input logic [8:0] x, input logic [7:0] y, input logic [1:0] m,
                            input logic [3:0] t, input logic b, input int budget);
        int n = 0;
        req_x = x; req_y = y; req_mem = m; req_tile = t; req_black = b;
        req_valid = 1'b1;
        while (!req_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) chk("push_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic tick_pulse();
        frame_tick = 1'b1;
        step(1);
        frame_tick = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((busy || count != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < budget, 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_go"}, go, 0);
        chk({tag, "_refresh"}, refresh, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_X"}, X, 0);
        chk({tag, "_Y"}, Y, 0);
        chk({tag, "_mem"}, memory_select, 0);
        chk({tag, "_tile"}, tile_select, 0);
        chk({tag, "_black"}, black, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_frame_dropped"}, frame_dropped, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[27];
        logic [9:0] exp_q[$];
        int base, go0, ref0, drop0;

        reset_n = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_mem = '0;
        req_tile = '0; req_black = 1'b0; frame_tick = 1'b0;
        step(3);
        chk_reset_state("reset");

        // Single draw, empty-queue refresh, dropped ticks, tick racing the refresh issue.
        tbl[0]  = mk(1,0,0, 0,0,0,0,0, 1, 0);
        tbl[1]  = mk(0,0,0, 1,0,1,0,0, 0, 10);
        tbl[2]  = mk(0,0,0, 0,0,1,0,0, 0, 10);
        tbl[3]  = mk(0,0,0, 0,0,1,0,0, 0, 10);
        tbl[4]  = mk(0,0,1, 0,0,1,0,0, 0, 10);
        tbl[5]  = mk(0,0,0, 0,0,0,0,0, 0, 10);
        tbl[6]  = mk(0,1,0, 0,0,0,0,0, 0, 10);
        tbl[7]  = mk(0,0,0, 0,1,1,0,0, 0, 10);
        tbl[8]  = mk(0,0,0, 0,0,1,0,0, 0, 10);
        tbl[9]  = mk(0,0,1, 0,0,1,1,0, 0, 10);
        tbl[10] = mk(0,0,1, 0,0,0,0,0, 0, 10);
        tbl[11] = mk(0,0,1, 0,0,0,0,0, 0, 10);
        tbl[12] = mk(0,1,0, 0,0,0,0,0, 0, 10);
        tbl[13] = mk(0,1,0, 0,1,1,0,1, 0, 10);
        tbl[14] = mk(0,0,0, 0,0,1,0,0, 0, 10);
        tbl[15] = mk(0,0,1, 0,0,1,1,0, 0, 10);
        tbl[16] = mk(0,0,0, 0,0,0,0,0, 0, 10);
        tbl[17] = mk(0,0,0, 0,0,0,0,0, 0, 10);
        tbl[18] = mk(0,1,0, 0,0,0,0,0, 0, 10);
        tbl[19] = mk(0,0,0, 0,1,1,0,0, 0, 10);
        tbl[20] = mk(0,1,0, 0,0,1,0,1, 0, 10);
        tbl[21] = mk(0,0,1, 0,0,1,1,0, 0, 10);
        tbl[22] = mk(0,0,0, 0,0,0,0,0, 0, 10);
        tbl[23] = mk(0,0,0, 0,1,1,0,0, 0, 10);
        tbl[24] = mk(0,0,0, 0,0,1,0,0, 0, 10);
        tbl[25] = mk(0,0,1, 0,0,1,1,0, 0, 10);
        tbl[26] = mk(0,0,0, 0,0,0,0,0, 0, 10);

        reset_n = 1'b1;
        req_x = 9'd10; req_y = 8'd20; req_mem = 2'b11; req_tile = 4'd5; req_black = 1'b0;
        for (int i = 0; i < 27; i++) begin
            req_valid  = tbl[i].vld;
            frame_tick = tbl[i].tick;
            tb_cf      = tbl[i].cf;
            step(1);
            chk($sformatf("tbl%0d_go", i),            go,            tbl[i].go);
            chk($sformatf("tbl%0d_refresh", i),       refresh,       tbl[i].rf);
            chk($sformatf("tbl%0d_busy", i),          busy,          tbl[i].busy);
            chk($sformatf("tbl%0d_frame_done", i),    frame_done,    tbl[i].fd);
            chk($sformatf("tbl%0d_frame_dropped", i), frame_dropped, tbl[i].drop);
            chk($sformatf("tbl%0d_count", i),         count,         tbl[i].cnt);
            chk($sformatf("tbl%0d_X", i),             X,             tbl[i].x);
        end
        req_valid = 1'b0; frame_tick = 1'b0; tb_cf = 1'b0;
        chk("held_Y", Y, 20);
        chk("held_tile", tile_select, 5);
        chk("held_mem", memory_select, 2'b11);
        chk("held_black", black, 0);

        // FIFO fill behind a stalled refresh: 16 accepted, 17th held off.
        eng_en = 1'b1; eng_hold = 1'b1; eng_lat = 2;
        base = log_q.size();
        tick_pulse();
        step(3);
        for (int i = 0; i < 16; i++)
            push_req(9'(100 + i), 8'(i), 2'b01, 4'(i), i[0], 20);
        chk("full_count", count, 16);
        chk("full_ready", req_ready, 0);
        req_x = 9'd116; req_y = 8'd16; req_mem = 2'b01; req_tile = 4'd0; req_black = 1'b0;
        req_valid = 1'b1;
        step(5);
        chk("held_off_count", count, 16);
        chk("held_off_ready", req_ready, 0);
        eng_hold = 1'b0;
        push_req(9'd116, 8'd16, 2'b01, 4'd0, 1'b0, 50);
        wait_drain(500);
        exp_q.delete();
        exp_q.push_back(REF);
        for (int i = 0; i < 17; i++) exp_q.push_back({1'b0, 9'(100 + i)});
        chk("fill_log_len", log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
            chk($sformatf("fill_log%0d", i), log_q[base + i], exp_q[i]);

        // 12 queued, two ticks: 8 draws, one refresh, 4 draws, one drop.
        eng_hold = 1'b1;
        base = log_q.size(); ref0 = n_ref; drop0 = n_drop;
        for (int i = 0; i < 13; i++)
            push_req(9'(200 + i), 8'(i), 2'b10, 4'(i), 1'b1, 20);
        step(3);
        chk("defer_count", count, 12);
        tick_pulse();
        step(2);
        tick_pulse();
        step(2);
        eng_hold = 1'b0;
        wait_drain(800);
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back({1'b0, 9'(200 + i)});
        exp_q.push_back(REF);
        for (int i = 9; i < 13; i++) exp_q.push_back({1'b0, 9'(200 + i)});
        chk("defer_log_len", log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++)
            chk($sformatf("defer_log%0d", i), log_q[base + i], exp_q[i]);
        chk("defer_refreshes", n_ref - ref0, 1);
        chk("defer_drops", n_drop - drop0, 1);

        // Reset while a draw waits for the engine with 3 more queued.
        eng_hold = 1'b1;
        for (int i = 0; i < 4; i++)
            push_req(9'(300 + i), 8'(i), 2'b00, 4'(i), 1'b0, 20);
        step(3);
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_count", count, 3);
        go0 = n_go;
        reset_n = 1'b0;
        step(1);
        chk_reset_state("midreset");
        reset_n = 1'b1;
        eng_hold = 1'b0;
        step(15);
        chk("post_reset_no_go", n_go - go0, 0);
        chk("post_reset_count", count, 0);
        chk("post_reset_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
